// File: rtl/serial_loader.sv
// serial_loader: serial-to-parallel front end for a parallel Register.
// Shifts in a WIDTH-bit word (MSB first) under a start/valid handshake,
// holds it on `data`, and pulses `ld` for one cycle so that the downstream
// Register (en <= ld, inp <= data) captures it.
// Optional feature macro: SERIAL_LOADER_PARITY_EN adds an even-parity bit
// after each word, a PARITY state and the `perr` output.
module serial_loader #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic [WIDTH-1:0] data,
  output logic             ld,
  output logic             busy
`ifdef SERIAL_LOADER_PARITY_EN
  ,
  output logic             perr
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

`ifdef SERIAL_LOADER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    LOAD   = 2'd2,
    PARITY = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;
`endif

  state_t           state_r;
  state_t           state_nx;
  logic [WIDTH-1:0] sh_r;
  logic [WIDTH-1:0] sh_nx;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx;
  logic [WIDTH-1:0] data_nx;
  logic             ld_nx;
  logic             busy_nx;
`ifdef SERIAL_LOADER_PARITY_EN
  logic             perr_nx;
`endif

  // Next-state, shift/count update and next values of the registered outputs.
  always_comb begin
    state_nx = state_r;
    sh_nx    = sh_r;
    cnt_nx   = cnt_r;
`ifdef SERIAL_LOADER_PARITY_EN
    perr_nx  = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          sh_nx    = '0;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      SHIFT: begin
        // start is deliberately not looked at here: a word in flight is never restarted.
        if (ser_valid) begin
          sh_nx  = {sh_r[WIDTH-2:0], ser_in};
          cnt_nx = cnt_r + CW'(1);
          if (cnt_r == LAST_BIT) begin
`ifdef SERIAL_LOADER_PARITY_EN
            state_nx = PARITY;
`else
            state_nx = LOAD;
`endif
          end else begin
            state_nx = SHIFT;
          end
        end else begin
          state_nx = SHIFT;
        end
      end
`ifdef SERIAL_LOADER_PARITY_EN
      PARITY: begin
        if (ser_valid) begin
          // Even parity: word bits plus parity bit must XOR to zero.
          if (((^sh_r) ^ ser_in) == 1'b0) begin
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
            perr_nx  = 1'b1;
          end
        end else begin
          state_nx = PARITY;
        end
      end
`endif
      LOAD: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        sh_nx    = '0;
        cnt_nx   = '0;
      end
    endcase

    // The output word is updated only on the edge that enters LOAD; sh_nx
    // already contains the final bit when coming straight from SHIFT.
    if (state_nx == LOAD) begin
      data_nx = sh_nx;
    end else begin
      data_nx = data;
    end
    ld_nx   = (state_nx == LOAD);
    busy_nx = (state_nx != IDLE);
  end

  // State, datapath and registered outputs; async reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      sh_r    <= '0;
      cnt_r   <= '0;
      data    <= '0;
      ld      <= 1'b0;
      busy    <= 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
      perr    <= 1'b0;
`endif
    end else begin
      state_r <= state_nx;
      sh_r    <= sh_nx;
      cnt_r   <= cnt_nx;
      data    <= data_nx;
      ld      <= ld_nx;
      busy    <= busy_nx;
`ifdef SERIAL_LOADER_PARITY_EN
      perr    <= perr_nx;
`endif
    end
  end

endmodule
